// File: rtl/controlador_spi_envio_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI transmit sequencer and related SPI
// blocks.
//   estado_spi_t    : sequencer state encoding
//   DIV_DEF         : default clock cycles per SCLK half-period
//   N_BITS_DEF      : default bits per transaction
//   DATA_W          : receive byte width
//   BIT_CNT_W       : width of the bit counter (holds 0..8)
//   es_temporizado  : true for states whose length is set by the DIV tick
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESHIFT,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } estado_spi_t;

  localparam int unsigned DIV_DEF    = 4;
  localparam int unsigned N_BITS_DEF = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(8) + 1;

  function automatic logic es_temporizado(input estado_spi_t e);
    return (e == SETUP) || (e == HIGH) || (e == LOW) || (e == HOLD);
  endfunction

endpackage

// File: rtl/controlador_spi_envio_if.sv
// -----------------------------------------------------------------------------
// controlador_spi_envio_if
// Bundles the request/response and SPI pin signals of the transmit sequencer.
//   start_i            : transaction request from sensor-access logic
//   miso_i             : serial data from the slave
//   carga_o            : load enable to the 9-bit transmit shift register
//   psclk_o            : shift strobe to the transmit shift register
//   sclk_o, cs_n_o     : SPI clock and active-low chip select
//   busy_o, done_o     : sequencer status and completion pulse
//   datos_recibidos_o  : received byte, right-aligned
// Modports: master = the sequencer, slave = everything around it.
// -----------------------------------------------------------------------------
interface controlador_spi_envio_if;
  import spi_pkg::*;

  logic              start_i;
  logic              miso_i;
  logic              carga_o;
  logic              psclk_o;
  logic              sclk_o;
  logic              cs_n_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] datos_recibidos_o;

  modport master (
    input  start_i,
    input  miso_i,
    output carga_o,
    output psclk_o,
    output sclk_o,
    output cs_n_o,
    output busy_o,
    output done_o,
    output datos_recibidos_o
  );

  modport slave (
    output start_i,
    output miso_i,
    input  carga_o,
    input  psclk_o,
    input  sclk_o,
    input  cs_n_o,
    input  busy_o,
    input  done_o,
    input  datos_recibidos_o
  );

endinterface

// File: rtl/controlador_spi_envio_tick.sv
// -----------------------------------------------------------------------------
// generador_tick_spi
// Counts 0..DIV-1 and flags the last count, giving a one-cycle tick every DIV
// cycles. A clear forces the count back to 0 on the next edge.
//   clck_i   : system clock
//   rst_n_i  : synchronous active-low reset
//   clr_i    : restart the count
//   cnt_o    : current count
//   tick_o   : high during the last cycle of each DIV-cycle period
// -----------------------------------------------------------------------------
module generador_tick_spi #(
  parameter int unsigned DIV = 4,
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clck_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clck_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controlador_spi_envio.sv
// -----------------------------------------------------------------------------
// controlador_spi_envio
// SPI mode-0 master sequencer for an external 9-bit MSB-out transmit shift
// register. Generates the register load and shift strobes, SCLK and CS_N,
// samples MISO into a receive byte and pulses done at the end.
//   clck_i   : system clock
//   rst_n_i  : synchronous active-low reset
//   bus      : controlador_spi_envio_if.master (start, miso, strobes, pins,
//              status and received byte)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start, CS_N high
//   LOAD     | one-cycle load strobe, CS_N falls
//   PRESHIFT | one shift strobe so the register presents its MSB
//   SETUP    | DIV cycles of SCLK low before the first rising edge
//   HIGH     | DIV cycles SCLK high, MISO sampled in the first cycle
//   LOW      | DIV cycles SCLK low, shift strobe in the first cycle
//   HOLD     | DIV cycles CS_N hold after the last bit, then done
// -----------------------------------------------------------------------------
module controlador_spi_envio
  import spi_pkg::*;
#(
  parameter int unsigned DIV    = DIV_DEF,
  parameter int unsigned N_BITS = N_BITS_DEF
) (
  input  logic                    clck_i,
  input  logic                    rst_n_i,
  controlador_spi_envio_if.master bus
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_ilegal
    $error("controlador_spi_envio: DIV must be at least 2");
  end
  if ((N_BITS < 1) || (N_BITS > 8)) begin : g_nbits_ilegal
    $error("controlador_spi_envio: N_BITS must be in 1..8");
  end

  estado_spi_t          estado_q, estado_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0]    datos_q, datos_d;
  logic                 carga_q, carga_d;
  logic                 psclk_q, psclk_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic [CW-1:0]        div_cnt;
  logic                 clr_div;
  logic                 ultimo_bit;
  logic                 fin;

  // Every state change restarts the half-period count, and untimed states
  // keep it parked at 0.
  assign clr_div    = (estado_d != estado_q) || !es_temporizado(estado_q);
  assign ultimo_bit = (bit_cnt_q == BIT_CNT_W'(N_BITS - 1));
  assign fin        = (estado_q == HOLD) && tick;

  generador_tick_spi #(
    .DIV (DIV)
  ) u_tick (
    .clck_i  (clck_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_div),
    .cnt_o   (div_cnt),
    .tick_o  (tick)
  );

  always_ff @(posedge clck_i) begin
    if (!rst_n_i) begin
      estado_q  <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      datos_q   <= '0;
      carga_q   <= 1'b0;
      psclk_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      datos_q   <= datos_d;
      carga_q   <= carga_d;
      psclk_q   <= psclk_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:     if (bus.start_i) estado_d = LOAD;
      LOAD:     estado_d = PRESHIFT;
      PRESHIFT: estado_d = SETUP;
      SETUP:    if (tick) estado_d = HIGH;
      HIGH:     if (tick) estado_d = ultimo_bit ? HOLD : LOW;
      LOW:      if (tick) estado_d = HIGH;
      HOLD:     if (tick) estado_d = IDLE;
      default:  estado_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    datos_d   = datos_q;

    if ((estado_q == LOAD) || fin) begin
      bit_cnt_d = '0;
    end else if ((estado_q == LOW) && tick) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end

    if (estado_q == LOAD) begin
      rx_d = '0;
    end else if ((estado_q == HIGH) && (div_cnt == '0)) begin
      rx_d = {rx_q[DATA_W-2:0], bus.miso_i};
    end

    if (fin) begin
      datos_d = rx_q;
    end

    carga_d = (estado_d == LOAD);
    psclk_d = (estado_d == PRESHIFT) || ((estado_d == LOW) && (estado_q != LOW));
    sclk_d  = (estado_d == HIGH);
    cs_n_d  = (estado_d == IDLE);
    busy_d  = (estado_d != IDLE);
    done_d  = fin;
  end

  assign bus.carga_o           = carga_q;
  assign bus.psclk_o           = psclk_q;
  assign bus.sclk_o            = sclk_q;
  assign bus.cs_n_o            = cs_n_q;
  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.datos_recibidos_o = datos_q;

endmodule

// File: tb/tb_controlador_spi_envio.sv
module tb_controlador_spi_envio;

  typedef struct {
    int esclavo;
    int envio;
  } stim_t;

  typedef struct {
    int ciclo;
    int datos;
    int subidas;
    int mosi;
    int alto;
  } fin_t;

  logic clck = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  controlador_spi_envio_if ifa ();
  controlador_spi_envio_if ifb ();

  controlador_spi_envio #(.DIV(4), .N_BITS(8)) dut (
    .clck_i  (clck),
    .rst_n_i (rst_n),
    .bus     (ifa.master)
  );

  controlador_spi_envio #(.DIV(2), .N_BITS(1)) dut_min (
    .clck_i  (clck),
    .rst_n_i (rst_n),
    .bus     (ifb.master)
  );

  // 9-bit MSB-out transmit shift register driven by the sequencer
  logic [8:0] tx_sr = '0;
  logic [7:0] datos_envio = '0;
  logic       mosi;
  assign mosi = tx_sr[8];
  always @(posedge clck) begin
    if (ifa.carga_o) tx_sr <= {1'b0, datos_envio};
    else if (ifa.psclk_o) tx_sr <= {tx_sr[7:0], 1'b0};
  end

  stim_t stim_q[$];
  int    qa_carga[$];
  int    qa_psclk[$];
  fin_t  qa_done[$];
  int    qb_carga[$];
  int    qb_psclk[$];
  fin_t  qb_done[$];

  task automatic chk(input string nombre, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nombre, act, req, cyc);
    end
  endtask

  task automatic ir_a(input int c);
    while (cyc < c) begin
      @(posedge clck);
      #1;
    end
  endtask

  // Expected response of one full default transaction accepted in cycle t0
  task automatic esperar_a(input int t0, input int esc, input int env);
    stim_t s;
    fin_t  f;
    s.esclavo = esc;
    s.envio   = env;
    stim_q.push_back(s);
    qa_carga.push_back(t0 + 1);
    qa_psclk.push_back(t0 + 2);
    for (int k = 0; k < 7; k++) qa_psclk.push_back(t0 + 11 + 8 * k);
    f.ciclo   = t0 + 71;
    f.datos   = esc;
    f.subidas = 8;
    f.mosi    = env;
    f.alto    = 0;
    qa_done.push_back(f);
  endtask

  // Monitor + slave model for the default instance
  logic [7:0] miso_sr = '0;
  logic [7:0] mosi_cap = '0;
  logic [7:0] datos_prev = '0;
  logic       sclk_prev = 1'b0;
  logic       rst_prev = 1'b1;
  int         subidas = 0;
  int         alto = 0;

  always @(negedge clck) begin
    stim_t s;
    fin_t  f;
    if (mon_on) begin
      chk("busy_vs_cs_n", int'(ifa.busy_o), int'(!ifa.cs_n_o));
      if (ifa.carga_o) begin
        chk("carga_cs_bajo", int'(ifa.cs_n_o), 0);
        if (qa_carga.size() == 0) chk("carga_inesperada", cyc, -1);
        else chk("carga_ciclo", cyc, qa_carga.pop_front());
        if (stim_q.size() > 0) begin
          s = stim_q.pop_front();
          miso_sr     = s.esclavo[7:0];
          datos_envio = s.envio[7:0];
        end
        ifa.miso_i = miso_sr[7];
        subidas  = 0;
        mosi_cap = '0;
      end
      if (ifa.psclk_o) begin
        if (qa_psclk.size() == 0) chk("psclk_inesperado", cyc, -1);
        else chk("psclk_ciclo", cyc, qa_psclk.pop_front());
      end
      if (ifa.sclk_o && !sclk_prev) begin
        subidas++;
        mosi_cap = {mosi_cap[6:0], mosi};
        alto = 0;
      end
      if (ifa.sclk_o) alto++;
      if (!ifa.sclk_o && sclk_prev) begin
        chk("sclk_alto_ciclos", alto, 4);
        miso_sr    = {miso_sr[6:0], 1'b0};
        ifa.miso_i = miso_sr[7];
      end
      if (ifa.done_o) begin
        chk("done_cs_alto", int'(ifa.cs_n_o), 1);
        if (qa_done.size() == 0) chk("done_inesperado", cyc, -1);
        else begin
          f = qa_done.pop_front();
          chk("done_ciclo", cyc, f.ciclo);
          chk("datos_recibidos", int'(ifa.datos_recibidos_o), f.datos);
          chk("sclk_subidas", subidas, f.subidas);
          chk("mosi_capturado", int'(mosi_cap), f.mosi);
        end
      end
      if (ifa.datos_recibidos_o != datos_prev)
        chk("datos_solo_en_done", int'(ifa.done_o || !rst_prev), 1);
    end
    sclk_prev  = ifa.sclk_o;
    datos_prev = ifa.datos_recibidos_o;
    rst_prev   = rst_n;
  end

  // Monitor for the DIV=2, N_BITS=1 instance
  logic sclk_prev_b = 1'b0;
  int   subidas_b = 0;
  int   alto_b = 0;

  always @(negedge clck) begin
    fin_t f;
    if (mon_on) begin
      if (ifb.carga_o) begin
        if (qb_carga.size() == 0) chk("min_carga_inesperada", cyc, -1);
        else chk("min_carga_ciclo", cyc, qb_carga.pop_front());
        subidas_b = 0;
        alto_b    = 0;
      end
      if (ifb.psclk_o) begin
        if (qb_psclk.size() == 0) chk("min_psclk_inesperado", cyc, -1);
        else chk("min_psclk_ciclo", cyc, qb_psclk.pop_front());
      end
      if (ifb.sclk_o) begin
        alto_b++;
        if (!sclk_prev_b) subidas_b++;
      end
      if (ifb.done_o) begin
        if (qb_done.size() == 0) chk("min_done_inesperado", cyc, -1);
        else begin
          f = qb_done.pop_front();
          chk("min_done_ciclo", cyc, f.ciclo);
          chk("min_datos_recibidos", int'(ifb.datos_recibidos_o), f.datos);
          chk("min_sclk_subidas", subidas_b, f.subidas);
          chk("min_sclk_alto", alto_b, f.alto);
        end
      end
    end
    sclk_prev_b = ifb.sclk_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    stim_t s;
    fin_t  f;
    rst_n = 1'b0;
    ifa.start_i = 1'b0;
    ifa.miso_i  = 1'b0;
    ifb.start_i = 1'b0;
    ifb.miso_i  = 1'b0;
    repeat (3) @(posedge clck);
    #1;
    rst_n = 1'b1;
    @(posedge clck);
    #1;

    chk("rst_cs_n", int'(ifa.cs_n_o), 1);
    chk("rst_sclk", int'(ifa.sclk_o), 0);
    chk("rst_carga", int'(ifa.carga_o), 0);
    chk("rst_psclk", int'(ifa.psclk_o), 0);
    chk("rst_busy", int'(ifa.busy_o), 0);
    chk("rst_done", int'(ifa.done_o), 0);
    chk("rst_datos", int'(ifa.datos_recibidos_o), 0);
    chk("rst_min_cs_n", int'(ifb.cs_n_o), 1);
    mon_on = 1'b1;

    // single transaction: slave returns 0xA5, register sends 0x3C
    t0 = cyc;
    ifa.start_i = 1'b1;
    esperar_a(t0, 'hA5, 'h3C);
    ir_a(t0 + 1);
    ifa.start_i = 1'b0;
    ir_a(t0 + 80);

    // start pulses while busy are ignored
    t0 = cyc;
    ifa.start_i = 1'b1;
    esperar_a(t0, 'h5A, 'hC3);
    ir_a(t0 + 1);
    ifa.start_i = 1'b0;
    ir_a(t0 + 10);
    chk("busy_en_transferencia", int'(ifa.busy_o), 1);
    ifa.start_i = 1'b1;
    ir_a(t0 + 11);
    ifa.start_i = 1'b0;
    ir_a(t0 + 40);
    ifa.start_i = 1'b1;
    ir_a(t0 + 41);
    ifa.start_i = 1'b0;
    ir_a(t0 + 80);

    // start held high: back-to-back transactions
    t0 = cyc;
    ifa.start_i = 1'b1;
    esperar_a(t0, 'h81, 'hF0);
    esperar_a(t0 + 71, 'h7E, 'h0F);
    ir_a(t0 + 70);
    chk("b2b_cs_bajo_antes", int'(ifa.cs_n_o), 0);
    ir_a(t0 + 71);
    chk("b2b_cs_alto_en_done", int'(ifa.cs_n_o), 1);
    chk("b2b_done", int'(ifa.done_o), 1);
    ir_a(t0 + 72);
    chk("b2b_cs_bajo_despues", int'(ifa.cs_n_o), 0);
    ifa.start_i = 1'b0;
    ir_a(t0 + 150);

    // reset in the middle of a transaction
    t0 = cyc;
    ifa.start_i = 1'b1;
    s.esclavo = 'h33;
    s.envio   = 'h55;
    stim_q.push_back(s);
    qa_carga.push_back(t0 + 1);
    qa_psclk.push_back(t0 + 2);
    qa_psclk.push_back(t0 + 11);
    qa_psclk.push_back(t0 + 19);
    qa_psclk.push_back(t0 + 27);
    ir_a(t0 + 1);
    ifa.start_i = 1'b0;
    ir_a(t0 + 30);
    rst_n = 1'b0;
    ir_a(t0 + 31);
    rst_n = 1'b1;
    chk("rstmid_cs_n", int'(ifa.cs_n_o), 1);
    chk("rstmid_sclk", int'(ifa.sclk_o), 0);
    chk("rstmid_busy", int'(ifa.busy_o), 0);
    chk("rstmid_datos", int'(ifa.datos_recibidos_o), 0);
    chk("rstmid_done", int'(ifa.done_o), 0);
    ir_a(t0 + 120);

    // DIV=2, N_BITS=1
    t0 = cyc;
    ifb.miso_i  = 1'b1;
    ifb.start_i = 1'b1;
    qb_carga.push_back(t0 + 1);
    qb_psclk.push_back(t0 + 2);
    f.ciclo = t0 + 9; f.datos = 1; f.subidas = 1; f.mosi = 0; f.alto = 2;
    qb_done.push_back(f);
    ir_a(t0 + 1);
    ifb.start_i = 1'b0;
    ir_a(t0 + 15);

    t0 = cyc;
    ifb.miso_i  = 1'b0;
    ifb.start_i = 1'b1;
    qb_carga.push_back(t0 + 1);
    qb_psclk.push_back(t0 + 2);
    f.ciclo = t0 + 9; f.datos = 0; f.subidas = 1; f.mosi = 0; f.alto = 2;
    qb_done.push_back(f);
    ir_a(t0 + 1);
    ifb.start_i = 1'b0;
    ir_a(t0 + 15);

    chk("pend_carga", qa_carga.size(), 0);
    chk("pend_psclk", qa_psclk.size(), 0);
    chk("pend_done", qa_done.size(), 0);
    chk("pend_min_carga", qb_carga.size(), 0);
    chk("pend_min_psclk", qb_psclk.size(), 0);
    chk("pend_min_done", qb_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
